// File: rtl/s64x7_bus_pkg.sv
// Shared definitions for the S64X7 bus responder: FSM encoding, default window base,
// byte-lane geometry.
package s64x7_bus_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StWait = 2'd1,
        StAck  = 2'd2
    } state_e;

    localparam logic [60:0] DefaultBase = 61'h1C00_0000_0000_0000;
    localparam int unsigned SelWidth    = 8;
    localparam int unsigned LaneBits    = 64 / SelWidth;

endpackage

// File: rtl/s64x7_ram64.sv
// 64-bit wide RAM: one synchronous byte-enabled write port, one registered read port
// (data valid the cycle after the address).
module s64x7_ram64
    import s64x7_bus_pkg::*;
#(
    parameter int unsigned AddrBits = 9
) (
    input  logic                clk_i,
    input  logic                wr_en_i,
    input  logic [AddrBits-1:0] wr_addr_i,
    input  logic [SelWidth-1:0] wr_be_i,
    input  logic [63:0]         wr_data_i,
    input  logic [AddrBits-1:0] rd_addr_i,
    output logic [63:0]         rd_data_o
);

    localparam int unsigned Depth = 1 << AddrBits;

    logic [63:0] mem_q [Depth];
    logic [63:0] rd_data_q;

    // Contents are deliberately never reset.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            for (int i = 0; i < SelWidth; i++) begin
                if (wr_be_i[i]) begin
                    mem_q[wr_addr_i][i*LaneBits +: LaneBits] <=
                        wr_data_i[i*LaneBits +: LaneBits];
                end
            end
        end
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/s64x7_bus_responder.sv
// S64X7 bus target fronting a local RAM window, with optional wait states, cycle abort
// on cyc_i drop, and discard of out-of-window or instruction-qualified writes.
module s64x7_bus_responder
    import s64x7_bus_pkg::*;
#(
    parameter int unsigned ADDR_BITS   = 9,
    parameter logic [60:0] BASE        = DefaultBase,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [63:3]         adr_i,
    input  logic                cyc_i,
    input  logic                stb_i,
    input  logic [SelWidth-1:0] sel_i,
    input  logic                we_i,
    input  logic                vpa_i,
    input  logic [63:0]         dat_i,
    output logic                ack_o,
    output logic [63:0]         dat_o
);

    localparam int unsigned WaitInit = (WAIT_STATES > 0) ? WAIT_STATES - 1 : 0;
    localparam logic [3:0]  WaitLoad = WaitInit[3:0];

    state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic [63:3]         adr_q;
    logic [SelWidth-1:0] sel_q;
    logic                we_q;
    logic                vpa_q;
    logic [63:0]         dat_q;

    logic                 accept;
    logic [60:0]          win_off;
    logic                 in_win;
    logic [ADDR_BITS-1:0] rd_idx;
    logic                 ram_we;
    logic [63:0]          ram_rdata;

    assign accept  = (state_q == StIdle) && cyc_i && stb_i;
    assign win_off = adr_q - BASE;
    assign in_win  = (win_off >> ADDR_BITS) == '0;

    // Look up the live address while idle so a zero-wait read has data ready in ACK.
    assign rd_idx = (state_q == StIdle) ? ADDR_BITS'(adr_i - BASE) : win_off[ADDR_BITS-1:0];

    assign ram_we = (state_q == StAck) && reset_i && we_q && !vpa_q && in_win;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    if (WAIT_STATES > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitLoad;
                    end else begin
                        state_d = StAck;
                    end
                end
            end
            StWait: begin
                if (!cyc_i) begin
                    state_d = StIdle;
                    cnt_d   = 4'd0;
                end else if (cnt_q == 4'd0) begin
                    state_d = StAck;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StAck: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            adr_q   <= '0;
            sel_q   <= '0;
            we_q    <= 1'b0;
            vpa_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                adr_q <= adr_i;
                sel_q <= sel_i;
                we_q  <= we_i;
                vpa_q <= vpa_i;
                dat_q <= dat_i;
            end
        end
    end

    s64x7_ram64 #(
        .AddrBits(ADDR_BITS)
    ) u_ram (
        .clk_i    (clk_i),
        .wr_en_i  (ram_we),
        .wr_addr_i(win_off[ADDR_BITS-1:0]),
        .wr_be_i  (sel_q),
        .wr_data_i(dat_q),
        .rd_addr_i(rd_idx),
        .rd_data_o(ram_rdata)
    );

    always_comb begin
        ack_o = (state_q == StAck);
        dat_o = '0;
        if (ack_o && !we_q && in_win) begin
            dat_o = ram_rdata;
        end
    end

endmodule

// File: tb/tb_s64x7_bus_responder.sv
// Bench for s64x7_bus_responder: three instances (0, 2 and 3 wait states) checked every
// cycle against a transaction-level model, plus literal read-back expectations.
module tb_s64x7_bus_responder;

    localparam logic [60:0] BaseW = 61'h1C00_0000_0000_0000;
    localparam int unsigned Ws0 = 0;
    localparam int unsigned Ws1 = 2;
    localparam int unsigned Ws2 = 3;

    int ws_of [3] = '{Ws0, Ws1, Ws2};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [63:3] adr  [3];
    logic        cyc  [3];
    logic        stb  [3];
    logic        we   [3];
    logic        vpa  [3];
    logic [7:0]  sel  [3];
    logic [63:0] wdat [3];
    logic [63:0] rdat [3];
    logic        ack  [3];

    logic        exp_ack [3];
    logic [63:0] exp_dat [3];
    logic [63:0] mem_m   [3][512];

    int checks   = 0;
    int failures = 0;
    bit chk_en   = 1'b0;

    s64x7_bus_responder #(.ADDR_BITS(9), .BASE(BaseW), .WAIT_STATES(Ws0)) u_dut0 (
        .clk_i(clk), .reset_i(reset_n), .adr_i(adr[0]), .cyc_i(cyc[0]), .stb_i(stb[0]),
        .sel_i(sel[0]), .we_i(we[0]), .vpa_i(vpa[0]), .dat_i(wdat[0]),
        .ack_o(ack[0]), .dat_o(rdat[0])
    );
    s64x7_bus_responder #(.ADDR_BITS(9), .BASE(BaseW), .WAIT_STATES(Ws1)) u_dut1 (
        .clk_i(clk), .reset_i(reset_n), .adr_i(adr[1]), .cyc_i(cyc[1]), .stb_i(stb[1]),
        .sel_i(sel[1]), .we_i(we[1]), .vpa_i(vpa[1]), .dat_i(wdat[1]),
        .ack_o(ack[1]), .dat_o(rdat[1])
    );
    s64x7_bus_responder #(.ADDR_BITS(9), .BASE(BaseW), .WAIT_STATES(Ws2)) u_dut2 (
        .clk_i(clk), .reset_i(reset_n), .adr_i(adr[2]), .cyc_i(cyc[2]), .stb_i(stb[2]),
        .sel_i(sel[2]), .we_i(we[2]), .vpa_i(vpa[2]), .dat_i(wdat[2]),
        .ack_o(ack[2]), .dat_o(rdat[2])
    );

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, req, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 3; i++) begin
                check64($sformatf("ack_dut%0d", i), {63'd0, ack[i]}, {63'd0, exp_ack[i]});
                check64($sformatf("dat_dut%0d", i), rdat[i], exp_dat[i]);
            end
        end
    end

    // One transfer on instance d, started just after a rising edge with that instance idle.
    task automatic xfer(input int d, input logic [63:0] ba, input logic w, input logic v,
                        input logic [7:0] s, input logic [63:0] data, input bit abort,
                        input bit keep, output logic [63:0] rd);
        logic [60:0] off;
        bit          inw;
        off = ba[63:3] - BaseW;
        inw = off < 61'd512;
        rd  = '0;
        adr[d] = ba[63:3]; we[d] = w; vpa[d] = v; sel[d] = s; wdat[d] = data;
        cyc[d] = 1'b1; stb[d] = 1'b1;
        @(posedge clk); #1;
        if (!keep) stb[d] = 1'b0;
        adr[d] = ~adr[d]; we[d] = ~w; vpa[d] = ~v; sel[d] = ~s; wdat[d] = ~data;
        if (abort) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
            @(posedge clk); #1;
            return;
        end
        for (int c = 0; c <= ws_of[d]; c++) begin
            if (c > 0) begin
                @(posedge clk); #1;
            end
            if (c == ws_of[d]) begin
                exp_ack[d] = 1'b1;
                exp_dat[d] = (!w && inw) ? mem_m[d][off[8:0]] : 64'd0;
                rd = rdat[d];
            end
        end
        @(posedge clk); #1;
        exp_ack[d] = 1'b0;
        exp_dat[d] = '0;
        if (w && !v && inw) begin
            for (int l = 0; l < 8; l++) begin
                if (s[l]) mem_m[d][off[8:0]][l*8 +: 8] = data[l*8 +: 8];
            end
        end
        if (!keep) begin
            cyc[d] = 1'b0;
            stb[d] = 1'b0;
        end
    endtask

    logic [63:0] r;

    initial begin
        for (int i = 0; i < 3; i++) begin
            adr[i] = '0; cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = 1'b0; vpa[i] = 1'b0;
            sel[i] = 8'hFF; wdat[i] = '0; exp_ack[i] = 1'b0; exp_dat[i] = '0;
        end

        // Reset held two edges with a strobe pending, then the first ack after release.
        @(posedge clk); #1;
        chk_en = 1'b1;
        @(posedge clk); #1;
        reset_n = 1'b1;
        for (int c = 0; c <= 4; c++) begin
            @(posedge clk); #1;
            if (c == 0) begin
                for (int i = 0; i < 3; i++) stb[i] = 1'b0;
            end
            for (int i = 0; i < 3; i++) begin
                exp_ack[i] = (c == ws_of[i]);
                exp_dat[i] = '0;
            end
        end
        for (int i = 0; i < 3; i++) cyc[i] = 1'b0;
        @(posedge clk); #1;

        // Byte lanes, zero wait states.
        xfer(0, 64'hE000_0000_0000_0008, 1, 0, 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_0008, 1, 0, 8'h02, 64'h4141_4141_4141_4141, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_0008, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("lanes_read", r, 64'hFFFF_FFFF_FFFF_41FF);

        // Two wait states.
        xfer(1, 64'hE000_0000_0000_0000, 1, 0, 8'hFF, 64'h0BAD_F00D_CAFE_0001, 0, 0, r);
        xfer(1, 64'hE000_0000_0000_0000, 0, 0, 8'h01, 64'd0, 0, 0, r);
        check64("wait2_read", r, 64'h0BAD_F00D_CAFE_0001);

        // Abort by cyc drop, and abandonment by reset while waiting.
        xfer(2, 64'hE000_0000_0000_0010, 1, 0, 8'hFF, 64'h0000_0000_0000_AAAA, 0, 0, r);
        xfer(2, 64'hE000_0000_0000_0010, 1, 0, 8'hFF, 64'h0000_0000_0000_1234, 1, 0, r);
        xfer(2, 64'hE000_0000_0000_0010, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("abort_read", r, 64'h0000_0000_0000_AAAA);
        adr[2] = 61'(64'hE000_0000_0000_0010 >> 3); we[2] = 1'b1; sel[2] = 8'hFF;
        wdat[2] = 64'h5555; cyc[2] = 1'b1; stb[2] = 1'b1;
        @(posedge clk); #1;
        stb[2] = 1'b0;
        reset_n = 1'b0;
        @(posedge clk); #1;
        reset_n = 1'b1;
        cyc[2] = 1'b0;
        @(posedge clk); #1;
        xfer(2, 64'hE000_0000_0000_0010, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("reset_abandon_read", r, 64'h0000_0000_0000_AAAA);

        // Out of window, vpa-qualified write, and aliasing one word past the window.
        xfer(0, 64'h0000_0000_1111_1110, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("oow_read", r, 64'd0);
        xfer(0, 64'hE000_0000_0000_0018, 1, 0, 8'hFF, 64'h1111_2222_3333_4444, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_0018, 1, 1, 8'hFF, 64'hDEAD_BEEF_DEAD_BEEF, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_0018, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("vpa_write_dropped", r, 64'h1111_2222_3333_4444);
        xfer(0, 64'hE000_0000_0000_0000, 1, 0, 8'hFF, 64'h0123_4567_89AB_CDEF, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_1000, 1, 0, 8'hFF, 64'hFFFF_0000_FFFF_0000, 0, 0, r);
        xfer(0, 64'hE000_0000_0000_0000, 0, 0, 8'hFF, 64'd0, 0, 0, r);
        check64("oow_write_dropped", r, 64'h0123_4567_89AB_CDEF);

        // Streaming reads with the strobe held high.
        for (int j = 0; j < 4; j++) begin
            xfer(0, 64'hE000_0000_0000_0020 + 64'(j * 8), 1, 0, 8'hFF,
                 64'h0101_0101_0101_0101 * 64'(j + 1), 0, 0, r);
        end
        for (int j = 0; j < 4; j++) begin
            xfer(0, 64'hE000_0000_0000_0020 + 64'(j * 8), 0, 0, 8'hFF, 64'd0, 0, (j < 3), r);
            check64($sformatf("stream_read%0d", j), r, 64'h0101_0101_0101_0101 * 64'(j + 1));
        end

        repeat (3) @(posedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/s64x7_bus_responder.md
S64X7_BUS_RESPONDER -- requirements
Module: s64x7_bus_responder

Interface
REQ-001 Parameter ADDR_BITS, default 9, meaning word-address bits of the local RAM (2^ADDR_BITS 64-bit words).
REQ-002 Parameter BASE, default 61'h1C00_0000_0000_0000, meaning the window base in 8-byte word units (byte address $E000_0000_0000_0000).
REQ-003 Parameter WAIT_STATES, default 0, meaning extra cycles inserted before ack_o; legal range is 0..15.
REQ-004 Port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 Port reset_i, input, 1 bit: synchronous, active-low reset; reset_i=0 at a rising edge resets the block.
REQ-006 Port adr_i, input, [63:3]: word address from the S64X7 initiator.
REQ-007 Port cyc_i, input, 1 bit: bus cycle in progress.
REQ-008 Port stb_i, input, 1 bit: transfer strobe.
REQ-009 Port sel_i, input, 8 bits: byte-lane enables; bit n selects dat bits [8n+7:8n].
REQ-010 Port we_i, input, 1 bit: 1 for write, 0 for read.
REQ-011 Port vpa_i, input, 1 bit: instruction fetch qualifier.
REQ-012 Port dat_i, input, 64 bits: write data from the initiator.
REQ-013 Port ack_o, output, 1 bit: transfer acknowledge.
REQ-014 Port dat_o, output, 64 bits: read data to the initiator.

Function
REQ-015 The FSM SHALL have the states IDLE, WAIT and ACK.
REQ-016 In IDLE, cyc_i&stb_i SHALL latch adr_i, sel_i, we_i, vpa_i and dat_i; the next state is WAIT if WAIT_STATES>0, otherwise ACK.
REQ-017 WAIT SHALL load a 4-bit counter with WAIT_STATES-1 on entry, decrement it each cycle, and go to ACK the cycle after it reaches 0.
REQ-018 ACK SHALL drive ack_o=1 for exactly one cycle, then return to IDLE unconditionally; ack_o=0 in all other states.
REQ-019 Acknowledge latency from the first cycle cyc_i&stb_i is sampled in IDLE SHALL be WAIT_STATES+1 cycles.
REQ-020 Back-to-back strobes SHALL incur one IDLE cycle between ACK and the next acceptance.
REQ-021 The address is in window when latched adr[63:3]-BASE < 2^ADDR_BITS; RAM index is adr[ADDR_BITS+2:3] relative to BASE.
REQ-022 A write SHALL update RAM only during ACK, only for in-window addresses, and only in lanes where latched sel=1.
REQ-023 A read SHALL present the full 64-bit RAM word on dat_o during ACK; lane masking is the initiator's job.
REQ-024 An out-of-window read SHALL ack with dat_o=0; an out-of-window write SHALL ack and be discarded.
REQ-025 A write with vpa latched =1 SHALL be acked and discarded.
REQ-026 dat_o SHALL be 0 whenever ack_o=0.
REQ-027 If cyc_i=0 is sampled in WAIT, the FSM SHALL abort to IDLE with no ack and no RAM write.
REQ-028 Changes on the input ports after acceptance SHALL NOT affect the transfer in progress; only the latched values are used.

Reset
REQ-029 While reset_i=0 at a clock edge, the FSM SHALL go to IDLE, the counter and latches SHALL clear, and ack_o=0, dat_o=0 from the next cycle.
REQ-030 A reset during WAIT or ACK SHALL abandon the transfer with no RAM write; RAM contents SHALL NOT be reset.

Structure
REQ-031 The header s64x7_bus.vh SHALL hold the FSM state encodings, the default BASE, and the sel lane width constant.
REQ-032 The RAM SHALL be a sub-module s64x7_ram64: one synchronous write port with 8 byte enables and one read port, read data valid the cycle after the address is presented.
REQ-033 The FSM SHALL issue the RAM read address one cycle before ACK so that read data is valid in ACK.

Verification
REQ-034 Reset: reset_i=0 for 2 cycles with cyc_i=stb_i=1 -> ack_o=0 and dat_o=0 throughout; the first ack arrives WAIT_STATES+1 cycles after reset_i=1.
REQ-035 Byte lanes (WAIT_STATES=0): write $FFFFFFFF_FFFFFFFF, sel $FF, to $E000_0000_0000_0008, then write $41414141_41414141 with sel 00000010, then read -> dat_o=$FFFFFFFF_FFFF41FF with ack_o=1 on cycle 2 after the strobe.
REQ-036 Wait states (WAIT_STATES=2): read of $E000_0000_0000_0000 -> ack_o=1 exactly on cycle 3 after acceptance, for one cycle only.
REQ-037 Abort (WAIT_STATES=3): write $1234 to $E000_0000_0000_0010, drop cyc_i in the first WAIT cycle -> no ack; a later read of that address returns the prior contents.
REQ-038 Out of window: read $0000_0000_1111_1110 -> ack_o=1, dat_o=0; a write with vpa_i=1 to $E000_0000_0000_0018 -> acked, and the word is unchanged on read-back.
REQ-039 Streaming: 4 consecutive reads with stb_i held high -> 4 acks, each followed by one ack_o=0 cycle, with the data of the matching addresses.
